csr_regfile: RTL and testbench

- Machine-mode control/status register file for the 5-stage RV32 core.
- Instantiated beside the integer register file and accessed by the ID stage:
  - one combinational read port for Zicsr instructions;
  - one generic write port;
  - dedicated trap-entry write ports for mepc/mcause/mtval plus an mstatus trap-entry update.

---
 rtl/csr_regfile_if.sv | 49 ++++
 rtl/csr_regfile.sv | 199 +++++++++++++++++++
 tb/tb_csr_regfile.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/csr_regfile_if.sv
// ----------------------------------------------------------------------------
// csr_regfile_if
//   Bundles the CSR access signals between the ID stage (master) and the
//   machine-mode CSR register file (slave).
//
//   Signals (named from the register file's point of view):
//     we_i / waddr_i / wdata_i          generic CSR write port
//     we_mepc_i / wdata_mepc_i          trap-entry write of mepc
//     we_mcause_i / wdata_mcause_i      trap-entry write of mcause
//     we_mtval_i / wdata_mtval_i        trap-entry write of mtval
//     exception_mie_req_i               trap-entry stacking of mstatus.MIE
//     raddr_i / rdata_o                 combinational read port
// ----------------------------------------------------------------------------
interface csr_regfile_if #(
    parameter int unsigned XLEN = 32
);
    logic            we_i;
    logic [11:0]     waddr_i;
    logic [XLEN-1:0] wdata_i;
    logic            we_mtval_i;
    logic [XLEN-1:0] wdata_mtval_i;
    logic            we_mepc_i;
    logic [XLEN-1:0] wdata_mepc_i;
    logic            we_mcause_i;
    logic [XLEN-1:0] wdata_mcause_i;
    logic            exception_mie_req_i;
    logic [11:0]     raddr_i;
    logic [XLEN-1:0] rdata_o;

    modport master (
        output we_i, waddr_i, wdata_i,
        output we_mtval_i, wdata_mtval_i,
        output we_mepc_i, wdata_mepc_i,
        output we_mcause_i, wdata_mcause_i,
        output exception_mie_req_i,
        output raddr_i,
        input  rdata_o
    );

    modport slave (
        input  we_i, waddr_i, wdata_i,
        input  we_mtval_i, wdata_mtval_i,
        input  we_mepc_i, wdata_mepc_i,
        input  we_mcause_i, wdata_mcause_i,
        input  exception_mie_req_i,
        input  raddr_i,
        output rdata_o
    );
endinterface

// File: rtl/csr_regfile.sv
// ----------------------------------------------------------------------------
// csr_regfile
//   Machine-mode control/status register file for the 5-stage RV32 core.
//   One combinational read port, one generic write port and dedicated
//   trap-entry ports for mepc/mcause/mtval plus the mstatus trap update.
//
//   Ports:
//     clk   rising-edge clock
//     rst   asynchronous, active-low reset
//     bus   csr_regfile_if.slave (write, trap-write and read signals)
//
//   Parameters:
//     XLEN      data width of every CSR (32)
//     HART_ID   value read from mhartid
//     MISA_VAL  constant value read from misa
//
//   Optional build macro:
//     CSR_CYCLE_COUNTER_EN  adds the 64-bit mcycle/mcycleh counter with
//                           read-only cycle/cycleh aliases. Undefined: those
//                           addresses read 0 and ignore writes.
// ----------------------------------------------------------------------------
module csr_regfile #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] HART_ID  = '0,
    parameter logic [XLEN-1:0] MISA_VAL = 32'h4000_1100
) (
    input  logic         clk,
    input  logic         rst,
    csr_regfile_if.slave bus
);

    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MISA      = 12'h301;
    localparam logic [11:0] ADDR_MIE       = 12'h304;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MTVAL     = 12'h343;
    localparam logic [11:0] ADDR_MIP       = 12'h344;
    localparam logic [11:0] ADDR_MVENDORID = 12'hF11;
    localparam logic [11:0] ADDR_MARCHID   = 12'hF12;
    localparam logic [11:0] ADDR_MIMPID    = 12'hF13;
    localparam logic [11:0] ADDR_MHARTID   = 12'hF14;
`ifdef CSR_CYCLE_COUNTER_EN
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
    localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
`endif

    // mstatus: MIE (bit 3) and MPIE (bit 7) writable, MPP [12:11] tied to M-mode.
    localparam logic [XLEN-1:0] MSTATUS_WMASK = XLEN'(32'h0000_0088);
    localparam logic [XLEN-1:0] MSTATUS_MPP   = XLEN'(32'h0000_1800);
    // mie/mip: only MSI/MTI/MEI (bits 3, 7, 11) exist.
    localparam logic [XLEN-1:0] IRQ_MASK      = XLEN'(32'h0000_0888);
    localparam logic [XLEN-1:0] MTVEC_MASK    = ~XLEN'(32'h0000_0002);
    localparam logic [XLEN-1:0] MEPC_MASK     = ~XLEN'(32'h0000_0003);

    localparam int unsigned MSTATUS_MIE_BIT  = 3;
    localparam int unsigned MSTATUS_MPIE_BIT = 7;

    logic [XLEN-1:0] mstatus_q,  mstatus_d;
    logic [XLEN-1:0] mie_q,      mie_d;
    logic [XLEN-1:0] mtvec_q,    mtvec_d;
    logic [XLEN-1:0] mscratch_q, mscratch_d;
    logic [XLEN-1:0] mepc_q,     mepc_d;
    logic [XLEN-1:0] mcause_q,   mcause_d;
    logic [XLEN-1:0] mtval_q,    mtval_d;
    logic [XLEN-1:0] mip_q,      mip_d;

    logic wr_mstatus, wr_mie, wr_mtvec, wr_mscratch;
    logic wr_mepc, wr_mcause, wr_mtval, wr_mip;

    logic [XLEN-1:0] rdata;

    // Generic write-port address decode.
    always_comb begin
        wr_mstatus  = bus.we_i && (bus.waddr_i == ADDR_MSTATUS);
        wr_mie      = bus.we_i && (bus.waddr_i == ADDR_MIE);
        wr_mtvec    = bus.we_i && (bus.waddr_i == ADDR_MTVEC);
        wr_mscratch = bus.we_i && (bus.waddr_i == ADDR_MSCRATCH);
        wr_mepc     = bus.we_i && (bus.waddr_i == ADDR_MEPC);
        wr_mcause   = bus.we_i && (bus.waddr_i == ADDR_MCAUSE);
        wr_mtval    = bus.we_i && (bus.waddr_i == ADDR_MTVAL);
        wr_mip      = bus.we_i && (bus.waddr_i == ADDR_MIP);
    end

    // Next-state: trap-entry ports take precedence over the generic port on
    // the same register; generic writes to other registers still commit.
    always_comb begin
        mstatus_d  = mstatus_q;
        mie_d      = mie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        mip_d      = mip_q;

        if (bus.exception_mie_req_i) begin
            mstatus_d                   = MSTATUS_MPP;
            mstatus_d[MSTATUS_MPIE_BIT] = mstatus_q[MSTATUS_MIE_BIT];
        end else if (wr_mstatus) begin
            mstatus_d = (bus.wdata_i & MSTATUS_WMASK) | MSTATUS_MPP;
        end

        if (wr_mie)      mie_d      = bus.wdata_i & IRQ_MASK;
        if (wr_mtvec)    mtvec_d    = bus.wdata_i & MTVEC_MASK;
        if (wr_mscratch) mscratch_d = bus.wdata_i;
        if (wr_mip)      mip_d      = bus.wdata_i & IRQ_MASK;

        if (bus.we_mepc_i)   mepc_d = bus.wdata_mepc_i & MEPC_MASK;
        else if (wr_mepc)    mepc_d = bus.wdata_i & MEPC_MASK;

        if (bus.we_mcause_i) mcause_d = bus.wdata_mcause_i;
        else if (wr_mcause)  mcause_d = bus.wdata_i;

        if (bus.we_mtval_i)  mtval_d = bus.wdata_mtval_i;
        else if (wr_mtval)   mtval_d = bus.wdata_i;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mstatus_q  <= MSTATUS_MPP;
            mie_q      <= '0;
            mtvec_q    <= '0;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            mip_q      <= '0;
        end else begin
            mstatus_q  <= mstatus_d;
            mie_q      <= mie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
            mip_q      <= mip_d;
        end
    end

`ifdef CSR_CYCLE_COUNTER_EN
    logic [63:0] cycle_q, cycle_d, cycle_inc;

    // A write replaces one half for this edge; the other half still follows
    // the increment, so a low-word write keeps the carry of the old low word.
    always_comb begin
        cycle_inc = cycle_q + 64'd1;
        cycle_d   = cycle_inc;
        if (bus.we_i && (bus.waddr_i == ADDR_MCYCLE)) begin
            cycle_d[31:0] = bus.wdata_i[31:0];
        end
        if (bus.we_i && (bus.waddr_i == ADDR_MCYCLEH)) begin
            cycle_d[63:32] = bus.wdata_i[31:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_d;
        end
    end
`endif

    // Combinational read; no bypass of a same-cycle write.
    always_comb begin
        rdata = '0;
        case (bus.raddr_i)
            ADDR_MSTATUS:   rdata = mstatus_q;
            ADDR_MISA:      rdata = MISA_VAL;
            ADDR_MIE:       rdata = mie_q;
            ADDR_MTVEC:     rdata = mtvec_q;
            ADDR_MSCRATCH:  rdata = mscratch_q;
            ADDR_MEPC:      rdata = mepc_q;
            ADDR_MCAUSE:    rdata = mcause_q;
            ADDR_MTVAL:     rdata = mtval_q;
            ADDR_MIP:       rdata = mip_q;
            ADDR_MVENDORID: rdata = '0;
            ADDR_MARCHID:   rdata = '0;
            ADDR_MIMPID:    rdata = '0;
            ADDR_MHARTID:   rdata = HART_ID;
`ifdef CSR_CYCLE_COUNTER_EN
            ADDR_MCYCLE,
            ADDR_CYCLE:     rdata = XLEN'(cycle_q[31:0]);
            ADDR_MCYCLEH,
            ADDR_CYCLEH:    rdata = XLEN'(cycle_q[63:32]);
`endif
            default:        rdata = '0;
        endcase
    end

    assign bus.rdata_o = rdata;

endmodule

// File: tb/tb_csr_regfile.sv
// ----------------------------------------------------------------------------
// tb_csr_regfile
//   Self-checking bench for csr_regfile: a table of write/read vectors with a
//   scoreboard queue, plus hand sequences for no-bypass, asynchronous reset
//   and the optional cycle counter (CSR_CYCLE_COUNTER_EN).
// ----------------------------------------------------------------------------
module tb_csr_regfile;

    logic clk    = 1'b0;
    logic rst    = 1'b0;
    logic clk_en = 1'b1;

    csr_regfile_if #(.XLEN(32)) bus ();

    csr_regfile #(
        .XLEN     (32),
        .HART_ID  (32'd0),
        .MISA_VAL (32'h4000_1100)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 if (clk_en) clk = ~clk;

    typedef struct {
        string       name;
        logic        we;
        logic [11:0] waddr;
        logic [31:0] wdata;
        logic        we_mepc;
        logic [31:0] mepc;
        logic        we_mcause;
        logic [31:0] mcause;
        logic        we_mtval;
        logic [31:0] mtval;
        logic        exc;
        logic [11:0] raddr;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] sb[$];
    int          errors = 0;
    int          checks = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    function automatic vec_t wr(input string nm, input logic [11:0] wa, input logic [31:0] wd,
                                input logic [11:0] ra, input logic [31:0] ex);
        vec_t v;
        v.name = nm; v.we = 1'b1; v.waddr = wa; v.wdata = wd;
        v.we_mepc = 1'b0; v.mepc = '0; v.we_mcause = 1'b0; v.mcause = '0;
        v.we_mtval = 1'b0; v.mtval = '0; v.exc = 1'b0;
        v.raddr = ra; v.exp = ex;
        return v;
    endfunction

    function automatic vec_t rd(input string nm, input logic [11:0] ra, input logic [31:0] ex);
        vec_t v;
        v = wr(nm, 12'h000, 32'h0, ra, ex);
        v.we = 1'b0;
        return v;
    endfunction

    task automatic idle_inputs();
        bus.we_i = 1'b0; bus.waddr_i = '0; bus.wdata_i = '0;
        bus.we_mepc_i = 1'b0; bus.wdata_mepc_i = '0;
        bus.we_mcause_i = 1'b0; bus.wdata_mcause_i = '0;
        bus.we_mtval_i = 1'b0; bus.wdata_mtval_i = '0;
        bus.exception_mie_req_i = 1'b0;
    endtask

    initial begin
        vec_t v;
        logic [31:0] exp_cnt_lo, exp_cnt_hi;

        idle_inputs();
        bus.raddr_i = 12'h300;

        // Table of vectors: each is driven for one edge, then read back.
        vecs.push_back(wr("mscratch_all1", 12'h340, 32'hFFFF_FFFF, 12'h340, 32'hFFFF_FFFF));
        vecs.push_back(wr("mstatus_mask",  12'h300, 32'hFFFF_FFFF, 12'h300, 32'h0000_1888));
        vecs.push_back(wr("mtvec_mask",    12'h305, 32'hFFFF_FFFF, 12'h305, 32'hFFFF_FFFD));
        vecs.push_back(wr("mepc_mask",     12'h341, 32'hFFFF_FFFF, 12'h341, 32'hFFFF_FFFC));
        vecs.push_back(wr("mie_mask",      12'h304, 32'hFFFF_FFFF, 12'h304, 32'h0000_0888));
        vecs.push_back(wr("mip_mask",      12'h344, 32'h0000_0FFF, 12'h344, 32'h0000_0888));
        vecs.push_back(wr("mstatus_mie1",  12'h300, 32'h0000_0008, 12'h300, 32'h0000_1808));
        v = rd("trap_mepc", 12'h341, 32'h8000_0120);
        v.we_mepc = 1'b1;   v.mepc   = 32'h8000_0123;
        v.we_mcause = 1'b1; v.mcause = 32'h0000_0002;
        v.we_mtval = 1'b1;  v.mtval  = 32'hDEAD_BEEF;
        v.exc = 1'b1;
        vecs.push_back(v);
        vecs.push_back(rd("trap_mcause",   12'h342, 32'h0000_0002));
        vecs.push_back(rd("trap_mtval",    12'h343, 32'hDEAD_BEEF));
        vecs.push_back(rd("trap_mstatus",  12'h300, 32'h0000_1880));
        v = wr("prio_mepc", 12'h341, 32'h1111_1110, 12'h341, 32'h2222_2220);
        v.we_mepc = 1'b1; v.mepc = 32'h2222_2220;
        vecs.push_back(v);
        v = wr("gen_other_commits", 12'h340, 32'h0000_1234, 12'h340, 32'h0000_1234);
        v.we_mepc = 1'b1; v.mepc = 32'h0000_0040;
        vecs.push_back(v);
        vecs.push_back(rd("trap_mepc_same", 12'h341, 32'h0000_0040));
        vecs.push_back(wr("mstatus_mie1b", 12'h300, 32'h0000_0008, 12'h300, 32'h0000_1808));
        v = wr("prio_mstatus", 12'h300, 32'h0000_0000, 12'h300, 32'h0000_1880);
        v.exc = 1'b1;
        vecs.push_back(v);
        vecs.push_back(wr("ro_mhartid",    12'hF14, 32'hFFFF_FFFF, 12'hF14, 32'h0000_0000));
        vecs.push_back(wr("unmapped_7c0",  12'h7C0, 32'hFFFF_FFFF, 12'h7C0, 32'h0000_0000));
        vecs.push_back(wr("ro_misa",       12'h301, 32'h0000_0000, 12'h301, 32'h4000_1100));
        vecs.push_back(rd("mscratch_kept", 12'h340, 32'h0000_1234));
        vecs.push_back(rd("mvendorid",     12'hF11, 32'h0000_0000));
        vecs.push_back(rd("marchid",       12'hF12, 32'h0000_0000));
        vecs.push_back(rd("mimpid",        12'hF13, 32'h0000_0000));
        vecs.push_back(wr("mcause_gen",    12'h342, 32'hFFFF_FFFF, 12'h342, 32'hFFFF_FFFF));
        vecs.push_back(wr("mtval_gen",     12'h343, 32'h1234_5678, 12'h343, 32'h1234_5678));
        v = rd("mcause_only", 12'h342, 32'h0000_0005);
        v.we_mcause = 1'b1; v.mcause = 32'h0000_0005;
        vecs.push_back(v);
        vecs.push_back(rd("mtval_indep",   12'h343, 32'h1234_5678));
        vecs.push_back(wr("mtvec_vectored", 12'h305, 32'h0000_0001, 12'h305, 32'h0000_0001));
        v = rd("exc_mie0", 12'h300, 32'h0000_1800);
        v.exc = 1'b1;
        vecs.push_back(v);
        vecs.push_back(wr("mstatus_final", 12'h300, 32'h0000_00FF, 12'h300, 32'h0000_1888));

        // Reset held for a few edges, released away from the rising edge.
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // A write is not visible in its own cycle.
        @(negedge clk);
        bus.we_i = 1'b1; bus.waddr_i = 12'h340; bus.wdata_i = 32'hA5A5_A5A5;
        bus.raddr_i = 12'h340;
        #1 check("no_bypass_same_cycle", bus.rdata_o, 32'h0000_0000);
        @(negedge clk);
        idle_inputs();
        #1 check("no_bypass_next_cycle", bus.rdata_o, 32'hA5A5_A5A5);

        foreach (vecs[i]) begin
            @(negedge clk);
            bus.we_i                = vecs[i].we;
            bus.waddr_i             = vecs[i].waddr;
            bus.wdata_i             = vecs[i].wdata;
            bus.we_mepc_i           = vecs[i].we_mepc;
            bus.wdata_mepc_i        = vecs[i].mepc;
            bus.we_mcause_i         = vecs[i].we_mcause;
            bus.wdata_mcause_i      = vecs[i].mcause;
            bus.we_mtval_i          = vecs[i].we_mtval;
            bus.wdata_mtval_i       = vecs[i].mtval;
            bus.exception_mie_req_i = vecs[i].exc;
            sb.push_back(vecs[i].exp);
            @(negedge clk);
            idle_inputs();
            bus.raddr_i = vecs[i].raddr;
            #1;
            if (sb.size() == 0) begin
                check({vecs[i].name, "_sb_empty"}, 32'h1, 32'h0);
            end else begin
                check(vecs[i].name, bus.rdata_o, sb.pop_front());
            end
        end

        // Asynchronous reset with the clock parked low.
        @(negedge clk);
        clk_en = 1'b0;
        #2 rst = 1'b0;
        bus.raddr_i = 12'h300; #1 check("async_rst_mstatus",  bus.rdata_o, 32'h0000_1800);
        bus.raddr_i = 12'h341; #1 check("async_rst_mepc",     bus.rdata_o, 32'h0000_0000);
        bus.raddr_i = 12'h305; #1 check("async_rst_mtvec",    bus.rdata_o, 32'h0000_0000);
        bus.raddr_i = 12'h340; #1 check("async_rst_mscratch", bus.rdata_o, 32'h0000_0000);
        clk_en = 1'b1;

        // Cycle counter: released on a falling edge, counted over 10 rising edges.
        @(negedge clk);
        rst = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
`ifdef CSR_CYCLE_COUNTER_EN
        exp_cnt_lo = 32'd10;
`else
        exp_cnt_lo = 32'd0;
`endif
        bus.raddr_i = 12'hB00; #1 check("mcycle_after_10", bus.rdata_o, exp_cnt_lo);
        bus.raddr_i = 12'hC00; #1 check("cycle_alias_10",  bus.rdata_o, exp_cnt_lo);

        bus.we_i = 1'b1; bus.waddr_i = 12'hB00; bus.wdata_i = 32'hFFFF_FFFF;
        @(negedge clk);
        idle_inputs();
`ifdef CSR_CYCLE_COUNTER_EN
        exp_cnt_lo = 32'hFFFF_FFFF;
`endif
        bus.raddr_i = 12'hB00; #1 check("mcycle_written", bus.rdata_o, exp_cnt_lo);
        @(negedge clk);
`ifdef CSR_CYCLE_COUNTER_EN
        exp_cnt_lo = 32'd0;
        exp_cnt_hi = 32'd1;
`else
        exp_cnt_lo = 32'd0;
        exp_cnt_hi = 32'd0;
`endif
        bus.raddr_i = 12'hB00; #1 check("mcycle_wrapped", bus.rdata_o, exp_cnt_lo);
        bus.raddr_i = 12'hB80; #1 check("mcycleh_carry",  bus.rdata_o, exp_cnt_hi);

        bus.we_i = 1'b1; bus.waddr_i = 12'hC80; bus.wdata_i = 32'hFFFF_FFFF;
        @(negedge clk);
        idle_inputs();
        bus.raddr_i = 12'hC80; #1 check("cycleh_ro", bus.rdata_o, exp_cnt_hi);

        bus.we_i = 1'b1; bus.waddr_i = 12'hB80; bus.wdata_i = 32'h0000_0005;
        @(negedge clk);
        idle_inputs();
`ifdef CSR_CYCLE_COUNTER_EN
        exp_cnt_hi = 32'd5;
`endif
        bus.raddr_i = 12'hB80; #1 check("mcycleh_write", bus.rdata_o, exp_cnt_hi);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time limit so the bench cannot hang.
    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected completion");
        $fatal(1, "timeout");
    end

endmodule
